mem_port_arbiter: RTL and testbench

- Owns the single byte-wide RAM port and shares it between the instruction-fetch stage and the MEM (load/store) stage.
- Each transaction is sequenced byte by byte. Read bytes are assembled little-endian into a 32-bit word; write bytes are split out the same way.
- A one-cycle done pulse goes back to the requester.
- Sits between the pipeline stages and the RAM, in place of the fetch stage driving RAM addresses directly.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Byte-wide RAM port arbiter shared by instruction fetch and the MEM stage.
// Each transaction is sequenced one byte per cycle. Read bytes are assembled
// little-endian into a 32-bit word, and store data is split out the same way.
// A one-cycle done pulse is returned to the requester.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | port free; arbitrate, MEM wins over IF
// S_IF_RD  | fetching 4 instruction bytes; cancel aborts
// S_MEM_RD | loading N bytes for the MEM stage
// S_MEM_WR | storing N bytes for the MEM stage
// S_DONE   | done pulse visible; requests ignored so requesters can drop req
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_cancel_i,
  output logic              if_done_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_RD,
    S_MEM_RD,
    S_MEM_WR,
    S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        cnt;      // index of the byte whose edge comes next (1..N)
  logic [2:0]        n_bytes;  // transaction length latched at accept
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd_buf;

  logic [31:0]       rd_word;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        next_wbyte;
  logic              last;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Merge the byte arriving this cycle into the partial read word and
  // pre-compute the next address and store byte.
  always_comb begin
    rd_word = rd_buf;
    case (cnt)
      3'd1:    rd_word[7:0]   = ram_din_i;
      3'd2:    rd_word[15:8]  = ram_din_i;
      3'd3:    rd_word[23:16] = ram_din_i;
      3'd4:    rd_word[31:24] = ram_din_i;
      default: rd_word = rd_buf;
    endcase
    next_addr = addr_q + ADDR_W'(cnt);
    case (cnt[1:0])
      2'd0:    next_wbyte = wdata_q[7:0];
      2'd1:    next_wbyte = wdata_q[15:8];
      2'd2:    next_wbyte = wdata_q[23:16];
      default: next_wbyte = wdata_q[31:24];
    endcase
    last = (cnt == n_bytes);
  end

  // Arbitration, byte sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      n_bytes     <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rd_buf      <= 32'd0;
      if_done_o   <= 1'b0;
      if_data_o   <= 32'd0;
      mem_done_o  <= 1'b0;
      mem_rdata_o <= 32'd0;
      busy_o      <= 1'b0;
      ram_a_o     <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= 8'd0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          ram_wr_o <= 1'b0;
          if (mem_req_i) begin
            addr_q  <= mem_addr_i;
            n_bytes <= len_to_n(mem_len_i);
            wdata_q <= mem_wdata_i;
            rd_buf  <= 32'd0;
            cnt     <= 3'd1;
            busy_o  <= 1'b1;
            ram_a_o <= mem_addr_i;
            if (mem_we_i) begin
              ram_wr_o   <= 1'b1;
              ram_dout_o <= mem_wdata_i[7:0];
              state      <= S_MEM_WR;
            end else begin
              state <= S_MEM_RD;
            end
          end else if (if_req_i) begin
            addr_q  <= if_addr_i;
            n_bytes <= 3'd4;
            rd_buf  <= 32'd0;
            cnt     <= 3'd1;
            busy_o  <= 1'b1;
            ram_a_o <= if_addr_i;
            state   <= S_IF_RD;
          end
        end

        S_IF_RD: begin
          if (if_cancel_i) begin
            // Flush: drop the fetch silently, keep the last fetched word.
            state    <= S_IDLE;
            busy_o   <= 1'b0;
            cnt      <= 3'd0;
            ram_wr_o <= 1'b0;
          end else begin
            rd_buf <= rd_word;
            if (last) begin
              if_data_o <= rd_word;
              if_done_o <= 1'b1;
              cnt       <= 3'd0;
              state     <= S_DONE;
            end else begin
              ram_a_o <= next_addr;
              cnt     <= cnt + 3'd1;
            end
          end
        end

        S_MEM_RD: begin
          rd_buf <= rd_word;
          if (last) begin
            mem_rdata_o <= rd_word;
            mem_done_o  <= 1'b1;
            cnt         <= 3'd0;
            state       <= S_DONE;
          end else begin
            ram_a_o <= next_addr;
            cnt     <= cnt + 3'd1;
          end
        end

        S_MEM_WR: begin
          if (last) begin
            ram_wr_o   <= 1'b0;
            mem_done_o <= 1'b1;
            cnt        <= 3'd0;
            state      <= S_DONE;
          end else begin
            ram_a_o    <= next_addr;
            ram_dout_o <= next_wbyte;
            cnt        <= cnt + 3'd1;
          end
        end

        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy_o   <= 1'b0;
          ram_wr_o <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a combinational RAM read model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_cancel_i;
  logic              if_done_o;
  logic [31:0]       if_data_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_len_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_done_o;
  logic [31:0]       mem_rdata_o;
  logic              busy_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_cancel_i(if_cancel_i),
    .if_done_o  (if_done_o),
    .if_data_o  (if_data_o),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .mem_len_i  (mem_len_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_done_o (mem_done_o),
    .mem_rdata_o(mem_rdata_o),
    .busy_o     (busy_o),
    .ram_a_o    (ram_a_o),
    .ram_wr_o   (ram_wr_o),
    .ram_dout_o (ram_dout_o),
    .ram_din_i  (ram_din_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_pat(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_1002: return 8'h10;
      32'h0000_1003: return 8'h00;
      32'h0000_2000: return 8'h11;
      32'h0000_2001: return 8'h22;
      32'h0000_2002: return 8'h33;
      32'h0000_2003: return 8'h44;
      32'h0000_3000: return 8'h80;
      32'hFFFF_FFFE: return 8'hAA;
      32'hFFFF_FFFF: return 8'hBB;
      32'h0000_0000: return 8'hCC;
      32'h0000_0001: return 8'hDD;
      default:       return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always_comb ram_din_i = ram_pat(ram_a_o);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req_i = 0; if_addr_i = '0; if_cancel_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_len_i = 2'b00; mem_addr_i = '0; mem_wdata_i = 32'd0;
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_ram_a", ram_a_o, 0);
    chk("rst_wr", ram_wr_o, 0);
    chk("rst_if_data", if_data_o, 0);
    rst = 1'b0;
    tick();

    // 1: IF read at 0x1000
    if_req_i = 1; if_addr_i = 32'h1000;
    tick();
    chk("if1_busy", busy_o, 1);
    chk("if1_a0", ram_a_o, 32'h1000);
    chk("if1_wr0", ram_wr_o, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("if1_a", ram_a_o, 32'h1000 + k);
      chk("if1_nodone", if_done_o, 0);
    end
    tick();
    chk("if1_done", if_done_o, 1);
    chk("if1_data", if_data_o, 32'h0010_0513);
    chk("if1_busy_done", busy_o, 1);
    if_req_i = 0;
    tick();
    chk("if1_done_clr", if_done_o, 0);
    chk("if1_idle", busy_o, 0);

    // 2: store halfword 0xBEEF at 0x2002
    mem_req_i = 1; mem_we_i = 1; mem_len_i = 2'b01; mem_addr_i = 32'h2002; mem_wdata_i = 32'h0000_BEEF;
    tick();
    chk("st_wr0", ram_wr_o, 1);
    chk("st_a0", ram_a_o, 32'h2002);
    chk("st_d0", ram_dout_o, 8'hEF);
    mem_wdata_i = 32'h1234_5678; mem_addr_i = 32'h9000;
    tick();
    chk("st_wr1", ram_wr_o, 1);
    chk("st_a1", ram_a_o, 32'h2003);
    chk("st_d1", ram_dout_o, 8'hBE);
    tick();
    chk("st_done", mem_done_o, 1);
    chk("st_wr_off", ram_wr_o, 0);
    chk("st_a_hold", ram_a_o, 32'h2003);
    mem_req_i = 0; mem_we_i = 0;
    tick();
    chk("st_done_clr", mem_done_o, 0);
    chk("st_wr_idle", ram_wr_o, 0);
    chk("st_idle", busy_o, 0);

    // 3: simultaneous requests, MEM wins with a byte load at 0x3000
    mem_req_i = 1; mem_we_i = 0; mem_len_i = 2'b00; mem_addr_i = 32'h3000;
    if_req_i = 1; if_addr_i = 32'h1000;
    tick();
    chk("arb_a", ram_a_o, 32'h3000);
    chk("arb_busy", busy_o, 1);
    tick();
    chk("arb_mdone", mem_done_o, 1);
    chk("arb_rdata", mem_rdata_o, 32'h0000_0080);
    chk("arb_ifnodone", if_done_o, 0);
    mem_req_i = 0;
    tick();
    chk("arb_gap_busy", busy_o, 0);
    chk("arb_gap_mdone", mem_done_o, 0);
    tick();
    chk("arb_if_busy", busy_o, 1);
    chk("arb_if_a0", ram_a_o, 32'h1000);
    tick(); tick(); tick();
    chk("arb_if_a3", ram_a_o, 32'h1003);
    tick();
    chk("arb_if_done", if_done_o, 1);
    chk("arb_if_data", if_data_o, 32'h0010_0513);
    chk("arb_excl", mem_done_o, 0);
    if_req_i = 0;
    tick();

    // 4: fetch cancelled in its second busy cycle, then a fetch at 0x2000
    if_req_i = 1; if_addr_i = 32'h1000;
    tick();
    tick();
    if_cancel_i = 1; if_addr_i = 32'h2000;
    tick();
    chk("cxl_idle", busy_o, 0);
    chk("cxl_nodone", if_done_o, 0);
    chk("cxl_data_hold", if_data_o, 32'h0010_0513);
    if_cancel_i = 0;
    tick();
    chk("cxl_re_busy", busy_o, 1);
    chk("cxl_re_a0", ram_a_o, 32'h2000);
    tick(); tick();
    chk("cxl_re_nodone", if_done_o, 0);
    tick(); tick();
    chk("cxl_re_done", if_done_o, 1);
    chk("cxl_re_data", if_data_o, 32'h4433_2211);
    if_req_i = 0;
    tick();

    // 5: reset in the middle of a word store
    mem_req_i = 1; mem_we_i = 1; mem_len_i = 2'b10; mem_addr_i = 32'h4000; mem_wdata_i = 32'hDEAD_BEEF;
    tick();
    chk("rs_a0", ram_a_o, 32'h4000);
    tick();
    chk("rs_d1", ram_dout_o, 8'hBE);
    rst = 1; mem_req_i = 0; mem_we_i = 0;
    tick();
    chk("rs_a", ram_a_o, 0);
    chk("rs_wr", ram_wr_o, 0);
    chk("rs_dout", ram_dout_o, 0);
    chk("rs_busy", busy_o, 0);
    chk("rs_mdone", mem_done_o, 0);
    chk("rs_if_data", if_data_o, 0);
    chk("rs_mrdata", mem_rdata_o, 0);
    rst = 0;
    tick();
    chk("rs_after_wr", ram_wr_o, 0);
    chk("rs_after_mdone", mem_done_o, 0);
    mem_req_i = 1; mem_we_i = 1; mem_len_i = 2'b00; mem_addr_i = 32'h5000; mem_wdata_i = 32'h0000_00A5;
    tick();
    chk("rs_new_wr", ram_wr_o, 1);
    chk("rs_new_a", ram_a_o, 32'h5000);
    chk("rs_new_d", ram_dout_o, 8'hA5);
    tick();
    chk("rs_new_done", mem_done_o, 1);
    chk("rs_new_wroff", ram_wr_o, 0);
    mem_req_i = 0; mem_we_i = 0;
    tick();

    // 6: word load across the address wrap
    mem_req_i = 1; mem_we_i = 0; mem_len_i = 2'b11; mem_addr_i = 32'hFFFF_FFFE;
    tick();
    chk("wrap_a0", ram_a_o, 32'hFFFF_FFFE);
    tick();
    chk("wrap_a1", ram_a_o, 32'hFFFF_FFFF);
    tick();
    chk("wrap_a2", ram_a_o, 32'h0000_0000);
    tick();
    chk("wrap_a3", ram_a_o, 32'h0000_0001);
    tick();
    chk("wrap_done", mem_done_o, 1);
    chk("wrap_rdata", mem_rdata_o, 32'hDDCC_BBAA);
    mem_req_i = 0;
    tick();
    chk("wrap_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
